// File: rtl/softmax_result_serializer.sv
// ============================================================================
// Module   : softmax_result_serializer
// Brief    : Captures an N-element softmax probability vector and streams it
//            out one W-bit element per cycle over valid/ready. Optional
//            element-sum checker enabled by SERIALIZER_SUM_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_result_serializer #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [N*W-1:0]         prob_flat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow
`ifdef SERIALIZER_SUM_CHECK_EN
    ,
    output logic [W+$clog2(N)-1:0] sum_out,
    output logic                   sum_valid
`endif
);

    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = W + IDX_W;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       cap_q [N];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               overflow_q, overflow_d;

    logic               w_hs;
    logic               w_final;
    logic               w_accept;
    logic [IDX_W-1:0]   w_idx_inc;

    assign w_hs      = out_valid_q & out_ready;
    assign w_final   = w_hs & (idx_q == IDX_W'(N - 1));
    // A new vector may land on the same edge as the final handshake.
    assign w_accept  = valid_in & ((state_q == S_IDLE) | ((state_q == S_SEND) & w_final));
    assign w_idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q | (valid_in & ~w_accept);
        if (w_accept) begin
            state_d     = S_SEND;
            idx_d       = '0;
            out_data_d  = prob_flat[W-1:0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
        end else if (w_final) begin
            state_d     = S_IDLE;
            idx_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else if (w_hs) begin
            idx_d       = w_idx_inc;
            out_data_d  = cap_q[w_idx_inc];
            out_last_d  = (w_idx_inc == IDX_W'(N - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            overflow_q  <= overflow_d;
        end
    end

    // Capture storage carries no reset; it is only read while streaming.
    generate
        for (genvar k = 0; k < N; k++) begin : g_cap
            always_ff @(posedge clk) begin
                if (!rst && w_accept) begin
                    cap_q[k] <= prob_flat[k*W +: W];
                end
            end
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == S_SEND);
    assign overflow  = overflow_q;

`ifdef SERIALIZER_SUM_CHECK_EN
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_out_q, sum_out_d;
    logic             sum_valid_q, sum_valid_d;
    logic [SUM_W-1:0] w_acc_next;

    assign w_acc_next = acc_q + SUM_W'(out_data_q);

    always_comb begin
        acc_d       = acc_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = w_final;
        if (w_hs) begin
            acc_d = w_acc_next;
        end
        if (w_final) begin
            sum_out_d = w_acc_next;
        end else if (w_accept) begin
            sum_out_d = '0;
        end
        if (w_accept) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_out   = sum_out_q;
    assign sum_valid = sum_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmax_result_serializer.sv
// ============================================================================
// Module   : tb_softmax_result_serializer
// Brief    : Self-checking bench for softmax_result_serializer against an
//            abstract vector/position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmax_result_serializer;

    localparam int N     = 64;
    localparam int W     = 16;
    localparam int IDX_W = $clog2(N);
    localparam int SUM_W = W + IDX_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic [N*W-1:0]     prob_flat;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               busy;
    logic               overflow;
`ifdef SERIALIZER_SUM_CHECK_EN
    logic [SUM_W-1:0]   sum_out;
    logic               sum_valid;
`endif

    softmax_result_serializer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .prob_flat (prob_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
`ifdef SERIALIZER_SUM_CHECK_EN
        ,
        .sum_out   (sum_out),
        .sum_valid (sum_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the vector being streamed and how far into it we are.
    logic [W-1:0]  m_vec [N];
    int            m_pos;
    bit            m_active;
    bit            m_ovf;
    longint        m_acc;
    longint        m_sum;
    bit            m_sum_known;
    bit            m_sum_valid;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_pos       = 0;
        m_ovf       = 0;
        m_acc       = 0;
        m_sum       = 0;
        m_sum_known = 1;
        m_sum_valid = 0;
    endtask

    task automatic model_step(input bit r, input bit v, input bit rdy);
        bit hs, fin, acc_ok;
        if (r) begin
            model_reset();
            return;
        end
        hs          = m_active && rdy;
        fin         = hs && (m_pos == N - 1);
        acc_ok      = v && (!m_active || fin);
        m_sum_valid = 0;
        if (hs) begin
            m_acc += longint'(m_vec[m_pos]);
            if (fin) begin
                m_active    = 0;
                m_sum       = m_acc;
                m_sum_known = 1;
                m_sum_valid = 1;
            end else begin
                m_pos++;
            end
        end
        if (v && !acc_ok) m_ovf = 1;
        if (acc_ok) begin
            for (int k = 0; k < N; k++) m_vec[k] = prob_flat[k*W +: W];
            m_pos    = 0;
            m_active = 1;
            m_acc    = 0;
            if (!fin) m_sum_known = 0;
        end
    endtask

    task automatic compare_outputs();
        chk("out_valid", 64'(out_valid), 64'(m_active));
        chk("busy",      64'(busy),      64'(m_active));
        chk("out_last",  64'(out_last),  64'(m_active && m_pos == N - 1));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        if (m_active) begin
            chk("out_data", 64'(out_data), 64'(m_vec[m_pos]));
            chk("out_idx",  64'(out_idx),  64'(m_pos));
        end
`ifdef SERIALIZER_SUM_CHECK_EN
        chk("sum_valid", 64'(sum_valid), 64'(m_sum_valid));
        if (m_sum_known) chk("sum_out", 64'(sum_out), 64'(m_sum));
`endif
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input bit r, input bit v, input bit rdy);
        rst       = r;
        valid_in  = v;
        out_ready = rdy;
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_step(r, v, rdy);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic load_vec(input int mode, input int base);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       prob_flat[k*W +: W] = W'(k + 1);
                1:       prob_flat[k*W +: W] = W'(base);
                2:       prob_flat[k*W +: W] = W'(base + k);
                default: prob_flat[k*W +: W] = W'($urandom);
            endcase
        end
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 400 && !(m_active && m_pos == p); i++) cycle(0, 0, 1);
    endtask

    task automatic drain(input bit rdy_pattern);
        for (int i = 0; i < 400 && m_active; i++)
            cycle(0, 0, rdy_pattern ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        out_ready = 1'b0;
        prob_flat = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_idx",   64'(out_idx),   64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
`ifdef SERIALIZER_SUM_CHECK_EN
        chk("rst_sum_out",   64'(sum_out),   64'd0);
        chk("rst_sum_valid", 64'(sum_valid), 64'd0);
`endif
        cycle(1, 0, 0);

        // Basic stream: element k = k+1, consumer always ready.
        load_vec(0, 0);
        cycle(0, 1, 1);
        chk("basic_first_data", 64'(out_data), 64'd1);
        chk("basic_first_idx",  64'(out_idx),  64'd0);
        for (int i = 0; i < N - 1; i++) cycle(0, 0, 1);
        chk("basic_last_data", 64'(out_data), 64'd64);
        chk("basic_last_flag", 64'(out_last), 64'd1);
        cycle(0, 0, 1);
        chk("basic_busy_done", 64'(busy), 64'd0);
        cycle(0, 0, 1);

        // Backpressure with ready pattern 1,0,0,1.
        load_vec(3, 0);
        cycle(0, 1, 1);
        drain(1'b1);
        cycle(0, 0, 1);

        // Back-to-back: next vector arrives on the final handshake.
        load_vec(0, 0);
        cycle(0, 1, 1);
        run_to_pos(N - 1);
        load_vec(2, 16'h0100);
        cycle(0, 1, 1);
        chk("b2b_data",     64'(out_data),  64'h100);
        chk("b2b_idx",      64'(out_idx),   64'd0);
        chk("b2b_overflow", 64'(overflow),  64'd0);
        drain(1'b0);

        // Overflow: a second vector at idx 10 is dropped.
        load_vec(3, 0);
        cycle(0, 1, 1);
        run_to_pos(10);
        load_vec(1, 16'hFFFF);
        cycle(0, 1, 1);
        chk("ovf_flag", 64'(overflow), 64'd1);
        drain(1'b0);
        cycle(0, 0, 1);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Reset at idx 20 with a coincident valid_in that must be ignored.
        load_vec(3, 0);
        cycle(0, 1, 1);
        run_to_pos(20);
        cycle(1, 1, 1);
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_data",     64'(out_data),  64'd0);
        chk("mid_rst_idx",      64'(out_idx),   64'd0);
        chk("mid_rst_last",     64'(out_last),  64'd0);
        chk("mid_rst_busy",     64'(busy),      64'd0);
        chk("mid_rst_overflow", 64'(overflow),  64'd0);
        load_vec(2, 16'h0A00);
        cycle(0, 1, 1);
        chk("restart_data", 64'(out_data), 64'h0A00);
        drain(1'b0);

`ifdef SERIALIZER_SUM_CHECK_EN
        load_vec(1, 16'h0400);
        cycle(0, 1, 1);
        drain(1'b0);
        chk("sum_pulse", 64'(sum_valid), 64'd1);
        chk("sum_value", 64'(sum_out),   64'h10000);
        cycle(0, 0, 1);
`endif

        // Randomised traffic: sparse vectors, mostly-ready consumer.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) load_vec(3, 0);
            cycle(($urandom_range(0, 999) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/softmax_result_serializer.md
# softmax_result_serializer

- Downstream stage of the softmax datapath.
- Captures the full `N`-element probability vector (`prob_flat`) when the softmax engine asserts `valid_out`.
- Streams the elements out one 16-bit word per cycle on a valid/ready interface, for a host/AXI-stream bridge or on-chip result buffer.
- The softmax engine has no backpressure, so vectors arriving while a stream is in progress are dropped and flagged.

## Interface
Parameters:
- `N`, 64, number of elements per vector (power of two, ≥ 2).
- `W`, 16, element width in bits.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  one-cycle pulse from softmax `valid_out`.
- `prob_flat`  in  N*W  probability vector; element k = `prob_flat[k*W +: W]`.
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_data`  out  W  current element.
- `out_idx`  out  $clog2(N)  index of the current element.
- `out_last`  out  1  high when `out_idx == N-1` and `out_valid`.
- `busy`  out  1  a vector is captured and not fully sent.
- `overflow`  out  1  sticky: a vector was dropped.
- `sum_out`  out  W+$clog2(N)  element sum (only with `SERIALIZER_SUM_CHECK_EN`).
- `sum_valid`  out  1  one-cycle pulse with a valid `sum_out` (only with `SERIALIZER_SUM_CHECK_EN`).

## Operation
- **States:** IDLE, SEND.
- **Capture register:** `N*W` bits.
- **Index counter:** `$clog2(N)` bits.
- **Handshake:** `hs = out_valid & out_ready`.
- **Internal accept:** `in_ready = (state==IDLE) | (state==SEND & hs & out_idx==N-1)`.
- **IDLE, `valid_in`:** capture `prob_flat`, set idx = 0, go to SEND.
- **SEND:**
  - `out_valid = 1`; `out_data` = captured element[idx].
  - On `hs` with idx < N-1: idx increments.
  - On `hs` with idx == N-1: go to IDLE. If `valid_in` is high in the same cycle, capture the new vector, set idx = 0, stay in SEND.
- **Drop rule:** `valid_in & ~in_ready` discards the vector and sets `overflow`. The current stream continues unchanged.
- **Overflow clear:** `overflow` clears only on `rst`.
- **Stability:** while `out_valid & ~out_ready`, `out_data`, `out_idx` and `out_last` hold stable.
- **`out_valid` deassertion:** `out_valid` never drops without a handshake, except on `rst`.
- **Outputs:** `busy = (state==SEND)`. The data path is pass-through; no arithmetic on element values.
- **Reset:** `rst` mid-stream aborts the stream, returns to IDLE and zeroes all outputs. A `valid_in` in the reset cycle is ignored and does not set `overflow`.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0, `busy`=0, `overflow`=0.
  - With the macro: `sum_out`=0, `sum_valid`=0.
- **First element:** `valid_in` at cycle t puts element 0 on the port with `out_valid`=1 at t+1.
- **Throughput:** with `out_ready` held high, element k is presented at t+1+k and the last at t+N.
- **Back-to-back vectors:** a new vector accepted on the final handshake at cycle c presents its element 0 at c+1. There is no bubble.
- **Outputs are registered:** `out_data`, `out_idx`, `out_last`, `out_valid` and `busy` all come from flops, with no combinational path from `out_ready`.

## Configuration
- **`SERIALIZER_SUM_CHECK_EN` defined:**
  - A `W+$clog2(N)`-bit accumulator clears on capture and adds `out_data` on each `hs`.
  - The cycle after the final handshake: `sum_out` = full element sum and `sum_valid`=1 for one cycle.
  - `sum_out` holds until the next capture or `rst`.
  - Used to check that the softmax output normalises to ≈1.0.
- **Not defined:** accumulator and the `sum_out`/`sum_valid` ports are absent. All other behaviour is identical.

## Test plan
- **Basic stream:** N=64, element k = k+1, `out_ready`=1, `valid_in` at t.
  - `out_data` = 1..64 on cycles t+1..t+64 with `out_idx` = 0..63.
  - `out_last` high only at t+64; `busy` low from t+65.
- **Backpressure:** `out_ready` toggles 1,0,0,1,…
  - Each element is held stable while stalled; no element is lost or duplicated.
  - All 64 delivered in order.
- **Overflow:** second `valid_in` (all elements 0xFFFF) while idx=10.
  - `overflow`=1 from the next cycle; the stream finishes with the original vector.
  - 0xFFFF never appears.
- **Back-to-back:** new vector (element k = 0x100+k) with `valid_in` coincident with the final handshake.
  - Next cycle `out_data`=0x100, `out_idx`=0; `overflow` stays 0.
- **Reset mid-stream:** `rst` for one cycle at idx=20.
  - All outputs 0 the following cycle; a fresh `valid_in` restarts from element 0.
- **Sum check (macro on):** all elements 0x0400, N=64.
  - `sum_valid` pulses one cycle after the last handshake with `sum_out` = 0x10000.
